divider_pipeline_bank: RTL and testbench

Parametrised multi-channel pipeline for divided-clock counter outputs (1/2, 1/4, ... counters), replacing fixed single-stage per-divider pipe registers. Each channel has a runtime-selectable delay of 0..MAX_DEPTH stages, a per-channel stall/enable, per-stage valid tracking, a global flush and a rising-edge pulse output. Sits between the divider counters and downstream logic that needs the divided signals delay-aligned.

---
 rtl/divider_pipe_pkg.sv | 11 +
 rtl/divider_pipe_channel.sv | 64 ++++++
 rtl/divider_pipeline_bank.sv | 39 +++
 tb/tb_divider_pipeline_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pipe_pkg.sv
// Shared constants and the depth clamp used by the divided-clock pipeline bank.
package divider_pipe_pkg;
  localparam int   DEPTH_W_DEF   = 3;
  localparam int   MAX_DEPTH_DEF = 4;
  localparam logic RESET_VAL_DEF = 1'b0;

  // Saturate an out-of-range depth request to the deepest tap.
  function automatic int depth_clamp(input int sel, input int max_depth);
    return (sel > max_depth) ? max_depth : sel;
  endfunction
endpackage

// File: rtl/divider_pipe_channel.sv
// One delay channel: shift stages with per-stage valids, clamped tap mux and
// edge history for the rising-edge pulse.
module divider_pipe_channel
  import divider_pipe_pkg::*;
#(
  parameter int   MAX_DEPTH = MAX_DEPTH_DEF,
  parameter int   DEPTH_W   = DEPTH_W_DEF,
  parameter logic RESET_VAL = RESET_VAL_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               enable,
  input  logic               signal_in,
  input  logic [DEPTH_W-1:0] depth_sel,
  output logic               pipe_out,
  output logic               pipe_valid,
  output logic               rise_pulse
);

  logic [MAX_DEPTH-1:0] stage;
  logic [MAX_DEPTH-1:0] valid;
  logic                 hist;
  int                   eff_depth;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage <= {MAX_DEPTH{RESET_VAL}};
      valid <= '0;
      hist  <= 1'b0;
    end else if (flush) begin
      stage <= {MAX_DEPTH{RESET_VAL}};
      valid <= '0;
      hist  <= 1'b0;
    end else begin
      if (enable) begin
        stage[0] <= signal_in;
        valid[0] <= 1'b1;
        for (int i = 1; i < MAX_DEPTH; i++) begin
          stage[i] <= stage[i-1];
          valid[i] <= valid[i-1];
        end
      end
      // History tracks every edge, so a stalled high output pulses only once.
      hist <= pipe_out & pipe_valid;
    end
  end

  // Depth 0 is a pure bypass; the tap can move without disturbing the stages.
  always_comb begin
    eff_depth  = depth_clamp(int'(depth_sel), MAX_DEPTH);
    pipe_out   = signal_in;
    pipe_valid = enable;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (eff_depth == i + 1) begin
        pipe_out   = stage[i];
        pipe_valid = valid[i];
      end
    end
  end

  assign rise_pulse = pipe_out & pipe_valid & ~hist;

endmodule

// File: rtl/divider_pipeline_bank.sv
// Bank of independently delayed divided-clock channels sharing reset and flush.
module divider_pipeline_bank
  import divider_pipe_pkg::*;
#(
  parameter int   NUM_CH    = 2,
  parameter int   MAX_DEPTH = MAX_DEPTH_DEF,
  parameter int   DEPTH_W   = DEPTH_W_DEF,
  parameter logic RESET_VAL = RESET_VAL_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_CH-1:0]         pipe_enable,
  input  logic [NUM_CH-1:0]         signal_in,
  input  logic [NUM_CH*DEPTH_W-1:0] depth_sel,
  output logic [NUM_CH-1:0]         pipe_out,
  output logic [NUM_CH-1:0]         pipe_valid,
  output logic [NUM_CH-1:0]         rise_pulse
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    divider_pipe_channel #(
      .MAX_DEPTH (MAX_DEPTH),
      .DEPTH_W   (DEPTH_W),
      .RESET_VAL (RESET_VAL)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .enable     (pipe_enable[n]),
      .signal_in  (signal_in[n]),
      .depth_sel  (depth_sel[n*DEPTH_W +: DEPTH_W]),
      .pipe_out   (pipe_out[n]),
      .pipe_valid (pipe_valid[n]),
      .rise_pulse (rise_pulse[n])
    );
  end

endmodule

// File: tb/tb_divider_pipeline_bank.sv
// Directed bench for divider_pipeline_bank: reset, latency sweep, clamp, stall,
// flush and on-the-fly depth change, all with hand-derived expectations.
module tb_divider_pipeline_bank;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic [1:0] pipe_enable;
  logic [1:0] signal_in;
  logic [5:0] depth_sel;
  logic [1:0] pipe_out;
  logic [1:0] pipe_valid;
  logic [1:0] rise_pulse;

  int total = 0;
  int bad   = 0;

  divider_pipeline_bank dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .pipe_enable (pipe_enable),
    .signal_in   (signal_in),
    .depth_sel   (depth_sel),
    .pipe_out    (pipe_out),
    .pipe_valid  (pipe_valid),
    .rise_pulse  (rise_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_depth(input int ch, input int d);
    depth_sel[ch*3 +: 3] = 3'(d);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // pattern 1,0,1,1,0 then zeros; bit j is the input before edge j
  logic [8:0] pat = 9'b0_0000_1101;
  logic       exp_out, exp_vld, exp_rise, prev_ov, last0;
  int         eff;

  initial begin
    reset = 1'b1; flush = 1'b0; pipe_enable = 2'b00; signal_in = 2'b00;
    depth_sel = '0;
    set_depth(0, 3); set_depth(1, 3);
    #3;
    chk("rst_out0", pipe_out[0], 1'b0);
    chk("rst_vld0", pipe_valid[0], 1'b0);
    chk("rst_rise0", rise_pulse[0], 1'b0);
    tick();
    reset = 1'b0;

    // first valid on 3rd enabled edge, single-cycle pulse
    pipe_enable = 2'b01; signal_in = 2'b01;
    tick(); chk("rst_rel_e1_vld", pipe_valid[0], 1'b0);
    tick(); chk("rst_rel_e2_vld", pipe_valid[0], 1'b0);
    tick(); chk("rst_rel_e3_vld", pipe_valid[0], 1'b1);
            chk("rst_rel_e3_out", pipe_out[0], 1'b1);
            chk("rst_rel_e3_rise", rise_pulse[0], 1'b1);
    tick(); chk("rst_rel_e4_rise", rise_pulse[0], 1'b0);
            chk("rst_rel_e4_vld", pipe_valid[0], 1'b1);

    // asynchronous reset mid-cycle with stages full
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out", pipe_out[0], 1'b0);
    chk("async_rst_vld", pipe_valid[0], 1'b0);
    pipe_enable = 2'b00;
    #1 reset = 1'b0;
    tick();

    // d=0 with enable low is not valid
    set_depth(0, 0); signal_in = 2'b01; #1;
    chk("d0_en_low_vld", pipe_valid[0], 1'b0);
    chk("d0_en_low_out", pipe_out[0], 1'b1);

    // latency sweep, including clamp of 7 to 4
    foreach (pat[k]) begin end
    for (int d = 0; d <= 5; d++) begin
      eff = (d == 5) ? 4 : d;
      set_depth(0, (d == 5) ? 7 : d);
      set_depth(1, 1);
      pipe_enable = 2'b11;
      do_flush();
      prev_ov = 1'b0;
      for (int j = 0; j < 9; j++) begin
        signal_in[0] = pat[j];
        #1;
        exp_vld  = (j >= eff);
        exp_out  = (j >= eff) ? pat[j-eff] : 1'b0;
        exp_rise = exp_out & exp_vld & ~prev_ov;
        chk($sformatf("sweep_d%0d_j%0d_out", d, j), pipe_out[0], exp_out);
        chk($sformatf("sweep_d%0d_j%0d_vld", d, j), pipe_valid[0], exp_vld);
        chk($sformatf("sweep_d%0d_j%0d_rise", d, j), rise_pulse[0], exp_rise);
        prev_ov = exp_out & exp_vld;
        tick();
      end
    end

    // stall ch1 (d=2) while ch0 (d=1) keeps shifting
    set_depth(0, 1); set_depth(1, 2);
    pipe_enable = 2'b11;
    do_flush();
    signal_in = 2'b11; tick();
    signal_in = 2'b00; tick();
    pipe_enable = 2'b01; signal_in = 2'b11; #1;
    chk("stall_load_out1", pipe_out[1], 1'b1);
    chk("stall_load_vld1", pipe_valid[1], 1'b1);
    chk("stall_load_rise1", rise_pulse[1], 1'b1);
    chk("stall_load_out0", pipe_out[0], 1'b0);
    for (int k = 0; k < 3; k++) begin
      last0 = signal_in[0];
      tick();
      chk($sformatf("stall%0d_out1", k), pipe_out[1], 1'b1);
      chk($sformatf("stall%0d_vld1", k), pipe_valid[1], 1'b1);
      chk($sformatf("stall%0d_rise1", k), rise_pulse[1], 1'b0);
      chk($sformatf("stall%0d_out0", k), pipe_out[0], last0);
      signal_in[0] = ~signal_in[0];
    end
    pipe_enable = 2'b11; signal_in[1] = 1'b1; #1;
    chk("reen_pre_out1", pipe_out[1], 1'b1);
    tick();
    chk("reen_e1_out1", pipe_out[1], 1'b0);
    chk("reen_e1_vld1", pipe_valid[1], 1'b1);
    signal_in[1] = 1'b0;
    tick();
    chk("reen_e2_out1", pipe_out[1], 1'b1);
    chk("reen_e2_rise1", rise_pulse[1], 1'b1);
    tick();
    chk("reen_e3_out1", pipe_out[1], 1'b0);

    // flush with stages full of ones and enable high
    set_depth(0, 4); set_depth(1, 2);
    pipe_enable = 2'b11; signal_in = 2'b11;
    repeat (5) tick();
    chk("full_vld0", pipe_valid[0], 1'b1);
    chk("full_out1", pipe_out[1], 1'b1);
    do_flush();
    chk("flush_vld0", pipe_valid[0], 1'b0);
    chk("flush_vld1", pipe_valid[1], 1'b0);
    chk("flush_out0", pipe_out[0], 1'b0);
    chk("flush_out1", pipe_out[1], 1'b0);
    chk("flush_rise1", rise_pulse[1], 1'b0);
    tick();
    chk("refill_e1_vld1", pipe_valid[1], 1'b0);
    tick();
    chk("refill_e2_vld1", pipe_valid[1], 1'b1);
    chk("refill_e2_rise1", rise_pulse[1], 1'b1);
    chk("refill_e2_vld0", pipe_valid[0], 1'b0);
    tick(); tick();
    chk("refill_e4_vld0", pipe_valid[0], 1'b1);

    // depth change on the fly
    do_flush();
    pipe_enable = 2'b01;
    signal_in[0] = 1'b1; tick(); tick(); tick();
    signal_in[0] = 1'b0; tick();
    chk("dchg_d4_out", pipe_out[0], 1'b1);
    chk("dchg_d4_vld", pipe_valid[0], 1'b1);
    pipe_enable = 2'b00;
    set_depth(0, 1); #1;
    chk("dchg_d1_out", pipe_out[0], 1'b0);
    chk("dchg_d1_vld", pipe_valid[0], 1'b1);
    do_flush();
    set_depth(0, 3); pipe_enable = 2'b01; signal_in[0] = 1'b1; #1;
    chk("dchg_d3_e0_vld", pipe_valid[0], 1'b0);
    tick(); chk("dchg_d3_e1_vld", pipe_valid[0], 1'b0);
    tick(); chk("dchg_d3_e2_vld", pipe_valid[0], 1'b0);
    tick(); chk("dchg_d3_e3_vld", pipe_valid[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
